// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;
  localparam int LINE_W = 128;
  localparam int ADDR_W = 28;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;
endpackage

// File: rtl/arb_pick2.sv
// Two-way winner select: write-back lock, then fixed priority, then round-robin.
module arb_pick2
  import mem_arb_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic req_i,
  input  logic req_d,
  input  logic rr_last,
  input  logic wb_lock,
  output logic any_req,
  output logic winner
);

  always_comb begin
    any_req = req_i | req_d;
    winner  = REQ_I;
    if (req_i && req_d) begin
      if (wb_lock || FIXED_PRIO) winner = REQ_D;
      else                       winner = (rr_last == REQ_I) ? REQ_D : REQ_I;
    end else if (req_d) begin
      winner = REQ_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one slow line-memory port between I-cache and D-cache, one transaction per grant.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0,
  parameter bit LOCK_WB    = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LINE_W-1:0] i_wdata,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  state_t state, state_next;
  logic   rr_last, wb_lock;
  logic   any_req, winner;
  logic   grant, done;

  arb_pick2 #(.FIXED_PRIO(FIXED_PRIO)) u_pick (
    .req_i   (i_read | i_write),
    .req_d   (d_read | d_write),
    .rr_last (rr_last),
    .wb_lock (wb_lock),
    .any_req (any_req),
    .winner  (winner)
  );

  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    grant      = 1'b0;
    done       = 1'b0;
    i_ready    = 1'b0;
    d_ready    = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          grant      = 1'b1;
          state_next = (winner == REQ_D) ? SERVE_D : SERVE_I;
        end
      end
      SERVE_I: begin
        if (mem_ready) begin
          i_ready    = 1'b1;
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      SERVE_D: begin
        if (mem_ready) begin
          d_ready    = 1'b1;
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Write wins over read when a requester raises both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rr_last   <= REQ_I;
      wb_lock   <= 1'b0;
    end else if (grant) begin
      if (winner == REQ_D) begin
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        mem_write <= d_write;
        mem_read  <= d_read & ~d_write;
      end else begin
        mem_addr  <= i_addr;
        mem_wdata <= i_wdata;
        mem_write <= i_write;
        mem_read  <= i_read & ~i_write;
      end
    end else if (done) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      rr_last   <= (state == SERVE_D) ? REQ_D : REQ_I;
      // mem_write still holds the latched command on the completing edge.
      wb_lock   <= LOCK_WB && (state == SERVE_D) && mem_write;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance 0 has LOCK_WB=1, instance 1 has LOCK_WB=0.
module tb_mem_arbiter;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_read [2], i_write [2], d_read [2], d_write [2];
  logic [27:0]  i_addr [2], d_addr [2], mem_addr [2];
  logic [127:0] i_wdata [2], d_wdata [2], i_rdata [2], d_rdata [2];
  logic [127:0] mem_wdata [2], mem_rdata [2];
  logic         i_ready [2], d_ready [2], mem_read [2], mem_write [2], mem_ready [2];

  int           lat [2];
  bit           auto_en [2];
  int           cnt [2];
  logic [127:0] rdata_pat [2];
  int           cyc = 0;
  int           n_pass = 0;
  int           n_total = 0;

  typedef struct {
    logic        who;
    logic        wr;
    logic [27:0] addr;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    mem_arbiter #(.FIXED_PRIO(1'b0), .LOCK_WB(k == 0)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_read    (i_read[k]),
      .i_write   (i_write[k]),
      .i_addr    (i_addr[k]),
      .i_wdata   (i_wdata[k]),
      .i_rdata   (i_rdata[k]),
      .i_ready   (i_ready[k]),
      .d_read    (d_read[k]),
      .d_write   (d_write[k]),
      .d_addr    (d_addr[k]),
      .d_wdata   (d_wdata[k]),
      .d_rdata   (d_rdata[k]),
      .d_ready   (d_ready[k]),
      .mem_read  (mem_read[k]),
      .mem_write (mem_write[k]),
      .mem_addr  (mem_addr[k]),
      .mem_wdata (mem_wdata[k]),
      .mem_rdata (mem_rdata[k]),
      .mem_ready (mem_ready[k])
    );
  end

  // One cycle: memory model drives at the negedge, observations are taken 1 ns later.
  task automatic tick(input int k);
    @(negedge clk);
    cyc++;
    if (mem_ready[k]) begin
      mem_ready[k] = 1'b0;
      cnt[k] = 0;
    end else if (auto_en[k] && (mem_read[k] || mem_write[k])) begin
      cnt[k]++;
      if (cnt[k] == lat[k]) begin
        mem_ready[k] = 1'b1;
        mem_rdata[k] = rdata_pat[k];
      end
    end
    #1;
  endtask

  task automatic do_reset();
    for (int k = 0; k < 2; k++) begin
      i_read[k] = 0; i_write[k] = 0; d_read[k] = 0; d_write[k] = 0;
      i_addr[k] = '0; d_addr[k] = '0; i_wdata[k] = '0; d_wdata[k] = '0;
      mem_rdata[k] = '0; mem_ready[k] = 0; cnt[k] = 0; auto_en[k] = 1; lat[k] = 3;
      rdata_pat[k] = '0;
    end
    sb.delete();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic wait_done(input int k, output bit ok, output logic ir, output logic dr,
                           output logic wr, output logic [27:0] addr,
                           output logic [127:0] wdata, output logic [127:0] rdata,
                           output int start_c, output int ready_c);
    ok = 0; start_c = -1; ready_c = -1;
    ir = 'x; dr = 'x; wr = 'x; addr = 'x; wdata = 'x; rdata = 'x;
    for (int n = 0; n < 60 && !ok; n++) begin
      tick(k);
      if (start_c < 0 && (mem_read[k] || mem_write[k])) start_c = cyc;
      if (mem_ready[k]) begin
        ok = 1; ir = i_ready[k]; dr = d_ready[k]; wr = mem_write[k];
        addr = mem_addr[k]; wdata = mem_wdata[k];
        rdata = dr ? d_rdata[k] : i_rdata[k];
        ready_c = cyc;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_total++;
    if ({mem_read[0], mem_write[0], mem_addr[0], mem_wdata[0]} !== '0)
      $display("FAIL reset_mem_regs: got rd=%b wr=%b addr=%h, expected all zero",
               mem_read[0], mem_write[0], mem_addr[0]);
    else n_pass++;
    n_total++;
    if ({i_ready[0], d_ready[0]} !== 2'b00)
      $display("FAIL reset_ready: got %b%b expected 00", i_ready[0], d_ready[0]);
    else n_pass++;
    auto_en[0] = 0;
    d_read[0] = 1; d_addr[0] = 28'h0000123;
    tick(0); tick(0);
    n_total++;
    if (mem_read[0] !== 1'b1 || mem_addr[0] !== 28'h0000123)
      $display("FAIL reset_pre_grant: got rd=%b addr=%h expected 1 0000123", mem_read[0], mem_addr[0]);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if (mem_read[0] !== 1'b0 || mem_addr[0] !== 28'h0)
      $display("FAIL reset_async: got rd=%b addr=%h expected 0 0000000", mem_read[0], mem_addr[0]);
    else n_pass++;
    d_read[0] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    tick(0);
    mem_ready[0] = 1'b1;
    #1;
    n_total++;
    if (d_ready[0] !== 1'b0 || i_ready[0] !== 1'b0)
      $display("FAIL reset_no_ready: got d=%b i=%b expected 0 0", d_ready[0], i_ready[0]);
    else n_pass++;
    tick(0);
    n_total++;
    if (mem_read[0] !== 1'b0)
      $display("FAIL reset_stays_idle: got mem_read=%b expected 0", mem_read[0]);
    else n_pass++;
  endtask

  task automatic test_single_i();
    bit ok; logic ir, dr, wr; logic [27:0] a; logic [127:0] wd, rd; int sc, rc, c0;
    exp_t e;
    do_reset();
    lat[0] = 4;
    rdata_pat[0] = {16{8'hA5}};
    i_read[0] = 1; i_addr[0] = 28'h0000040;
    sb.push_back('{who: 1'b0, wr: 1'b0, addr: 28'h0000040});
    c0 = cyc;
    wait_done(0, ok, ir, dr, wr, a, wd, rd, sc, rc);
    e = sb.pop_front();
    n_total++;
    if (!ok) $display("FAIL single_timeout: no mem_ready within budget");
    else n_pass++;
    n_total++;
    if (sc - c0 !== 1) $display("FAIL single_latency: got %0d cycles expected 1", sc - c0);
    else n_pass++;
    n_total++;
    if (ir !== 1'b1 || dr !== e.who) $display("FAIL single_ready: got i=%b d=%b expected 1 0", ir, dr);
    else n_pass++;
    n_total++;
    if (a !== e.addr || wr !== e.wr) $display("FAIL single_cmd: got addr=%h wr=%b expected %h %b", a, wr, e.addr, e.wr);
    else n_pass++;
    n_total++;
    if (rd !== {16{8'hA5}}) $display("FAIL single_rdata: got %h expected a5 repeated", rd);
    else n_pass++;
    n_total++;
    if (rc - sc !== 3) $display("FAIL single_hold: got %0d expected 3", rc - sc);
    else n_pass++;
    i_read[0] = 0;
    tick(0);
    n_total++;
    if (i_ready[0] !== 1'b0 || mem_read[0] !== 1'b0)
      $display("FAIL single_one_pulse: got i_ready=%b mem_read=%b expected 0 0", i_ready[0], mem_read[0]);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    bit ok; logic ir, dr, wr; logic [27:0] a; logic [127:0] wd, rd; int sc, rc, prev_rc;
    exp_t e;
    do_reset();
    lat[1] = 2;
    i_read[1] = 1; i_addr[1] = 28'h0000010;
    d_read[1] = 1; d_addr[1] = 28'h0000020;
    for (int n = 0; n < 4; n++) begin
      logic w;
      w = (n % 2 == 0);
      sb.push_back('{who: w, wr: 1'b0, addr: w ? 28'h0000020 : 28'h0000010});
    end
    prev_rc = -1;
    for (int n = 0; n < 4; n++) begin
      rdata_pat[1] = {4{32'h1000_0000 + 32'(n)}};
      wait_done(1, ok, ir, dr, wr, a, wd, rd, sc, rc);
      e = sb.pop_front();
      n_total++;
      if (!ok || dr !== e.who || ir !== !e.who)
        $display("FAIL rr_grant_%0d: got ok=%b i=%b d=%b expected d=%b", n, ok, ir, dr, e.who);
      else n_pass++;
      n_total++;
      if (a !== e.addr || rd !== {4{32'h1000_0000 + 32'(n)}})
        $display("FAIL rr_data_%0d: got addr=%h rdata=%h expected %h", n, a, rd, e.addr);
      else n_pass++;
      if (n > 0) begin
        n_total++;
        if (sc - prev_rc !== 2) $display("FAIL rr_spacing_%0d: got %0d expected 2", n, sc - prev_rc);
        else n_pass++;
      end
      prev_rc = rc;
    end
    i_read[1] = 0; d_read[1] = 0;
  endtask

  task automatic test_wb_lock(input int k);
    bit ok; logic ir, dr, wr; logic [27:0] a; logic [127:0] wd, rd; int sc, rc;
    exp_t e;
    do_reset();
    i_read[k] = 1; i_addr[k] = 28'h0000040;
    d_write[k] = 1; d_addr[k] = 28'h0000800; d_wdata[k] = {4{32'hCAFE_0001}};
    sb.push_back('{who: 1'b1, wr: 1'b1, addr: 28'h0000800});
    if (k == 0) begin
      sb.push_back('{who: 1'b1, wr: 1'b0, addr: 28'h0000100});
      sb.push_back('{who: 1'b0, wr: 1'b0, addr: 28'h0000040});
    end else begin
      sb.push_back('{who: 1'b0, wr: 1'b0, addr: 28'h0000040});
      sb.push_back('{who: 1'b1, wr: 1'b0, addr: 28'h0000100});
    end
    for (int n = 0; n < 3; n++) begin
      wait_done(k, ok, ir, dr, wr, a, wd, rd, sc, rc);
      e = sb.pop_front();
      n_total++;
      if (!ok || dr !== e.who || ir !== !e.who)
        $display("FAIL lock%0d_order_%0d: got ok=%b i=%b d=%b expected d=%b", k, n, ok, ir, dr, e.who);
      else n_pass++;
      n_total++;
      if (wr !== e.wr || a !== e.addr)
        $display("FAIL lock%0d_cmd_%0d: got wr=%b addr=%h expected %b %h", k, n, wr, a, e.wr, e.addr);
      else n_pass++;
      if (dr === 1'b1 && d_write[k]) begin
        d_write[k] = 0; d_read[k] = 1; d_addr[k] = 28'h0000100;
      end else if (dr === 1'b1) begin
        d_read[k] = 0;
      end else if (ir === 1'b1) begin
        i_read[k] = 0;
      end
    end
    i_read[k] = 0; d_read[k] = 0; d_write[k] = 0;
  endtask

  task automatic test_latched();
    bit ok; logic ir, dr, wr; logic [27:0] a; logic [127:0] wd, rd; int sc, rc;
    exp_t e;
    do_reset();
    lat[0] = 5;
    d_read[0] = 1; d_write[0] = 1; d_addr[0] = 28'h0000555; d_wdata[0] = {4{32'hDEAD_BEEF}};
    sb.push_back('{who: 1'b1, wr: 1'b1, addr: 28'h0000555});
    tick(0); tick(0);
    d_addr[0] = 28'h0FFFFFF; d_wdata[0] = ~{4{32'hDEAD_BEEF}}; d_write[0] = 0;
    tick(0);
    n_total++;
    if (mem_addr[0] !== 28'h0000555 || mem_write[0] !== 1'b1)
      $display("FAIL latch_mid: got addr=%h wr=%b expected 0000555 1", mem_addr[0], mem_write[0]);
    else n_pass++;
    wait_done(0, ok, ir, dr, wr, a, wd, rd, sc, rc);
    e = sb.pop_front();
    n_total++;
    if (!ok || dr !== e.who) $display("FAIL latch_ready: got ok=%b d=%b expected 1 1", ok, dr);
    else n_pass++;
    n_total++;
    if (a !== e.addr || wr !== e.wr) $display("FAIL latch_cmd: got addr=%h wr=%b expected %h %b", a, wr, e.addr, e.wr);
    else n_pass++;
    n_total++;
    if (wd !== {4{32'hDEAD_BEEF}}) $display("FAIL latch_wdata: got %h expected deadbeef repeated", wd);
    else n_pass++;
    d_read[0] = 0;
  endtask

  task automatic test_stray();
    bit ok; logic ir, dr, wr; logic [27:0] a; logic [127:0] wd, rd; int sc, rc;
    exp_t e;
    do_reset();
    auto_en[0] = 0;
    tick(0);
    mem_ready[0] = 1'b1;
    #1;
    n_total++;
    if (i_ready[0] !== 1'b0 || d_ready[0] !== 1'b0)
      $display("FAIL stray_ready: got i=%b d=%b expected 0 0", i_ready[0], d_ready[0]);
    else n_pass++;
    tick(0);
    n_total++;
    if (mem_read[0] !== 1'b0 || mem_write[0] !== 1'b0)
      $display("FAIL stray_state: got rd=%b wr=%b expected 0 0", mem_read[0], mem_write[0]);
    else n_pass++;
    auto_en[0] = 1; lat[0] = 2;
    i_read[0] = 1; i_addr[0] = 28'h0000077;
    sb.push_back('{who: 1'b0, wr: 1'b0, addr: 28'h0000077});
    wait_done(0, ok, ir, dr, wr, a, wd, rd, sc, rc);
    e = sb.pop_front();
    n_total++;
    if (!ok || ir !== 1'b1 || dr !== e.who || a !== e.addr)
      $display("FAIL stray_after: got ok=%b i=%b d=%b addr=%h expected 1 1 0 %h", ok, ir, dr, a, e.addr);
    else n_pass++;
    i_read[0] = 0;
  endtask

  initial begin
    test_reset();
    test_single_i();
    test_round_robin();
    test_wb_lock(0);
    test_wb_lock(1);
    test_latched();
    test_stray();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
